// File: rtl/csr_gpio_pkg.sv
// Shared constants and types for the CSR-mapped GPIO unit: CSR addresses,
// seven-segment patterns and the switch debounce state encoding.
package csr_gpio_pkg;

    localparam logic [11:0] CSR_IO0_ADDR = 12'hF00;
    localparam logic [11:0] CSR_IO2_ADDR = 12'hF02;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE,
        COUNT
    } db_state_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG7_LUT[nibble];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch input conditioning: multi-stage synchronizer followed by a debounce
// FSM that accepts a new value only after it has been stable long enough.
module sw_debounce
    import csr_gpio_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 18,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic [SW_WIDTH-1:0] sw_db,
    output logic                sw_changed
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [SW_WIDTH-1:0] sw_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    db_state_t           state_q, state_d;
    logic [SW_WIDTH-1:0] cand_q, cand_d;
    logic [SW_WIDTH-1:0] db_q, db_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                changed_q, changed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            db_q      <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw_s != db_q) begin
                    cand_d  = sw_s;
                    cnt_d   = CNT_W'(1);
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (sw_s != cand_q) begin
                    // A bounce back to the accepted value abandons the attempt;
                    // a bounce to some third value restarts the count on it.
                    if (sw_s == db_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cand_d = sw_s;
                        cnt_d  = CNT_W'(1);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    db_d      = cand_q;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sw_db      = db_q;
    assign sw_changed = changed_q;

endmodule

// File: rtl/csr_gpio_unit.sv
// CSR-mapped GPIO responder: HEX output register with registered seven-segment
// drive, and a read-only debounced switch register, both reached via csrrw.
module csr_gpio_unit
    import csr_gpio_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 18,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [11:0] CSR_SW_ADDR     = CSR_IO0_ADDR,
    parameter logic [11:0] CSR_HEX_ADDR    = CSR_IO2_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gpio_we,
    input  logic [11:0]         csr_addr,
    input  logic [31:0]         csr_wdata,
    output logic [31:0]         csr_rdata,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic                sw_changed,
    output logic [31:0]         hex_value,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic [6:0]          hex4,
    output logic [6:0]          hex5,
    output logic [6:0]          hex6,
    output logic [6:0]          hex7
);

    logic [31:0]         hex_reg;
    logic [6:0]          seg_q [8];
    logic [SW_WIDTH-1:0] sw_db;

    sw_debounce #(
        .SW_WIDTH       (SW_WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .sw_db     (sw_db),
        .sw_changed(sw_changed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hex_reg <= '0;
        end else if (gpio_we && (csr_addr == CSR_HEX_ADDR)) begin
            hex_reg <= csr_wdata;
        end
    end

    // Segments are decoded from the registered value, so digits trail hex_reg by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                seg_q[i] <= SEG_BLANK;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                seg_q[i] <= seg7_decode(hex_reg[4*i +: 4]);
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_addr == CSR_SW_ADDR) begin
            csr_rdata = 32'(sw_db);
        end else if (csr_addr == CSR_HEX_ADDR) begin
            csr_rdata = hex_reg;
        end
    end

    assign hex_value = hex_reg;
    assign hex0      = seg_q[0];
    assign hex1      = seg_q[1];
    assign hex2      = seg_q[2];
    assign hex3      = seg_q[3];
    assign hex4      = seg_q[4];
    assign hex5      = seg_q[5];
    assign hex6      = seg_q[6];
    assign hex7      = seg_q[7];

endmodule
